// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
// Clocked exhaustive sweep of an N_IN-bit stimulus vector. Each vector is held
// for DWELL cycles; on the last cycle of the hold the N_IMP implementation
// outputs are compared. The mismatching vectors are counted, and the first
// failing vector and its disagreement mask are captured.
// Optional build macro: GATE_SWEEP_GOLDEN_NAND_EN. When defined, every
// implementation is compared against an internal NAND reference (~&stim),
// so a fault shared by all implementations is also caught. When undefined,
// the implementations are compared against implementation 0 (a unanimity
// check), which works for any gate type.
module gate_sweep_checker #(
  parameter int N_IN  = 3,
  parameter int N_IMP = 3,
  parameter int DWELL = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   stim,
  input  logic [N_IMP-1:0]  dut_y,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_cnt,
  output logic [N_IN-1:0]   first_err_vec,
  output logic [N_IMP-1:0]  first_err_mask
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);
  localparam logic [N_IN-1:0]  LAST_VEC = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [N_IN-1:0]    stim_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic [N_IN:0]      err_cnt_q;
  logic [N_IN-1:0]    first_err_vec_q;
  logic [N_IMP-1:0]   first_err_mask_q;

  logic               ref_d;
  logic [N_IMP-1:0]   mask_d;
  logic               mismatch_d;
  logic               sample_d;
  logic [N_IN:0]      err_cnt_d;

  // Mismatch mask against the reference bit and the would-be error count
  always_comb begin
`ifdef GATE_SWEEP_GOLDEN_NAND_EN
    ref_d = ~&stim_q;
`else
    ref_d = dut_y[0];
`endif
    mask_d     = dut_y ^ {N_IMP{ref_d}};
    mismatch_d = |mask_d;
    sample_d   = (cnt_q == LAST_CNT);
    err_cnt_d  = err_cnt_q + {{N_IN{1'b0}}, mismatch_d};
  end

  // Sweep FSM: start/restart, dwell counting, sampling and result capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      stim_q           <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_cnt_q        <= '0;
      first_err_vec_q  <= '0;
      first_err_mask_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q          <= RUN;
            cnt_q            <= '0;
            stim_q           <= '0;
            busy_q           <= 1'b1;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            err_cnt_q        <= '0;
            first_err_vec_q  <= '0;
            first_err_mask_q <= '0;
          end
        end
        RUN: begin
          if (sample_d) begin
            cnt_q     <= '0;
            err_cnt_q <= err_cnt_d;
            // err_cnt_q still zero means this is the first failing vector
            if (mismatch_d && (err_cnt_q == '0)) begin
              first_err_vec_q  <= stim_q;
              first_err_mask_q <= mask_d;
            end
            if (stim_q == LAST_VEC) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_cnt_d == '0);
              stim_q  <= '0;
            end else begin
              stim_q <= stim_q + N_IN'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stim           = stim_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_vec  = first_err_vec_q;
  assign first_err_mask = first_err_mask_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Testbench for gate_sweep_checker: behavioural gate models driven from
// per-implementation truth tables, a sweep-level reference model feeding a
// scoreboard queue, and a monitor that checks results whenever done rises.
module tb_gate_sweep_checker;

  localparam int N_IN  = 3;
  localparam int N_IMP = 3;
  localparam int DWELL = 4;
  localparam int NV    = 1 << N_IN;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [N_IN-1:0]   stim;
  logic [N_IMP-1:0]  dut_y;
  logic              busy;
  logic              done;
  logic              pass;
  logic [N_IN:0]     err_cnt;
  logic [N_IN-1:0]   first_err_vec;
  logic [N_IMP-1:0]  first_err_mask;

  gate_sweep_checker #(.N_IN(N_IN), .N_IMP(N_IMP), .DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(stim), .dut_y(dut_y),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_vec(first_err_vec), .first_err_mask(first_err_mask)
  );

  always #5 clk = ~clk;

  // Each implementation is a truth table indexed by the stimulus vector
  logic [NV-1:0] tt [N_IMP];

  always_comb begin
    dut_y = '0;
    for (int i = 0; i < N_IMP; i++) dut_y[i] = tt[i][stim];
  end

  typedef struct {
    logic p;
    int   ec;
    int   fv;
    int   fm;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic logic [NV-1:0] nand_tt();
    logic [NV-1:0]   t;
    logic [N_IN-1:0] v;
    for (int k = 0; k < NV; k++) begin
      v    = k[N_IN-1:0];
      t[k] = ~&v;
    end
    return t;
  endfunction

  // Reference: walk every vector, compare each implementation with the
  // reference bit, count failing vectors and remember the first one.
  function automatic exp_t model();
    exp_t            e;
    logic [N_IN-1:0] v;
    logic            r;
    int              m;
    bit              found;
    e.ec = 0; e.fv = 0; e.fm = 0; found = 0;
    for (int k = 0; k < NV; k++) begin
      v = k[N_IN-1:0];
`ifdef GATE_SWEEP_GOLDEN_NAND_EN
      r = ~&v;
`else
      r = tt[0][k];
`endif
      m = 0;
      for (int i = 0; i < N_IMP; i++) if (tt[i][k] != r) m += (1 << i);
      if (m != 0) begin
        e.ec++;
        if (!found) begin
          found = 1;
          e.fv  = k;
          e.fm  = m;
        end
      end
    end
    e.p = (e.ec == 0);
    return e;
  endfunction

  task automatic set_all(input logic [NV-1:0] t);
    for (int i = 0; i < N_IMP; i++) tt[i] = t;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_stim"}, 32'(stim), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 0);
    check({tag, "_first_err_vec"}, 32'(first_err_vec), 0);
    check({tag, "_first_err_mask"}, 32'(first_err_mask), 0);
  endtask

  // Push the prediction, issue start (pulsed or held), wait for done
  task automatic do_sweep(input bit hold_start);
    bit got;
    int c;
    sb.push_back(model());
    @(negedge clk);
    start = 1'b1;
    if (!hold_start) begin
      @(negedge clk);
      start = 1'b0;
    end
    got = 0;
    c   = 0;
    while (!got && c < NV * DWELL + 20) begin
      @(negedge clk);
      c++;
      if (done) got = 1;
    end
    start = 1'b0;
    if (!got) begin
      check("sweep_timeout", 0, 1);
      sb.delete();
    end
  endtask

  // Monitor: track busy length and stimulus progression, score on done rise
  initial begin
    int   k    = 0;
    int   serr = 0;
    logic dprev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        k = 0; serr = 0; dprev = 1'b0;
      end else begin
        if (done && !dprev) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            check("pass", 32'(pass), 32'(e.p));
            check("err_cnt", 32'(err_cnt), e.ec);
            check("first_err_vec", 32'(first_err_vec), e.fv);
            check("first_err_mask", 32'(first_err_mask), e.fm);
            check("busy_cycles", k, NV * DWELL);
            check("stim_sequence_errors", serr, 0);
            check("stim_after_done", 32'(stim), 0);
          end
        end
        dprev = done;
        if (busy) begin
          k++;
          if (int'(stim) != (k - 1) / DWELL) serr++;
        end else begin
          k = 0;
          serr = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [NV-1:0] good;
    int            c;
    good  = nand_tt();
    rst_n = 1'b0;
    start = 1'b0;
    set_all(good);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_reset_values("reset");

    // Clean sweep of three correct NANDs
    do_sweep(0);

    // Implementation 2 stuck-at-0
    tt[2] = '0;
    do_sweep(0);

    // Common-mode stuck-at-1
    set_all('1);
    do_sweep(0);

    // Reset mid-sweep while stim = 5, then a full sweep from scratch
    set_all(good);
    tt[2] = '0;
    sb.push_back(model());
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (stim != 3'b101 && c < NV * DWELL + 20) begin
      @(negedge clk);
      c++;
    end
    check("reach_stim5", 32'(stim), 5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_values("midreset");
    void'(sb.pop_back());
    @(negedge clk);
    do_sweep(0);

    // Start held high through a faulty sweep, then a clean restart
    set_all(good);
    tt[1] = '0;
    do_sweep(1);
    set_all(good);
    do_sweep(0);

    // Randomized sparse faults
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N_IMP; i++) begin
        tt[i] = good ^ (NV'($urandom) & NV'($urandom) & NV'($urandom));
      end
      do_sweep($urandom_range(0, 1) == 1);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
